// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine for MULT/MULTU/DIV/DIVU.
// Operands are captured as magnitudes, iterated WIDTH times, and sign-fixed into HI/LO.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_zero;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Operand decode at capture: signed modes work on magnitudes
    logic             w_signed;
    logic             w_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed = ~op[0];
    assign w_div    = op[1];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_b_zero = (b == '0);
    assign w_last   = (r_cnt == CW'(WIDTH));

    // Multiply step: add multiplicand into upper half when LSB set, then shift right
    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;
    assign w_addend = r_acc[0] ? {1'b0, r_opnd} : '0;
    assign w_sum    = {1'b0, r_acc[AW-1:WIDTH]} + w_addend;

    // Divide step: restoring shift-subtract, remainder in upper half, quotient shifts in below
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_q_ok;
    logic [AW-1:0]    w_step;
    assign w_shift = r_acc[AW-1:WIDTH-1];
    assign w_diff  = w_shift - {1'b0, r_opnd};
    assign w_q_ok  = ~w_diff[WIDTH];
    assign w_step  = r_is_div
                   ? {(w_q_ok ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_q_ok}
                   : {w_sum, r_acc[WIDTH-1:1]};

    // Sign correction applied on the way out of FIX
    logic [AW-1:0]    w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;
    assign w_prod   = r_neg_lo ? -r_acc : r_acc;
    assign w_quo    = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_neg_hi ? -r_acc[AW-1:WIDTH] : r_acc[AW-1:WIDTH];
    assign w_fix_hi = r_is_div ? w_rem : w_prod[AW-1:WIDTH];
    assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = (w_div && w_b_zero) ? FIX : RUN;
            RUN:     if (w_last) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_zero   <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_dbz    <= 1'b0;
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_opnd   <= w_b_mag;
                        r_is_div <= w_div;
                        r_zero   <= w_div && w_b_zero;
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= w_a_neg;
                    end
                end
                RUN: begin
                    if (!w_last) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_zero) begin
                        r_dbz <= 1'b1;
                    end else begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model compared every cycle,
// plus directed vectors with literal HI/LO and latency expectations.
module tb_muldiv_unit;
    localparam int unsigned W  = 32;
    localparam int unsigned W8 = 8;

    logic clk = 1'b0;
    logic reset;

    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, dbz;
    logic [W-1:0]  hi, lo;

    logic          start8;
    logic [1:0]    op8;
    logic [W8-1:0] a8, b8;
    logic          busy8, done8, dbz8;
    logic [W8-1:0] hi8, lo8;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {div_by_zero, hi, lo}
    function automatic logic [2*W:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        longint sx, sy, ux, uy, p, q, r;
        logic [2*W-1:0] res;
        logic z;
        z  = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        res = '0;
        case (o)
            2'b00: begin p = sx * sy; res = p; end
            2'b01: begin p = ux * uy; res = p; end
            2'b10: begin
                if (y == '0) z = 1'b1;
                else begin q = sx / sy; r = sx % sy; res = {r[W-1:0], q[W-1:0]}; end
            end
            default: begin
                if (y == '0) z = 1'b1;
                else begin q = ux / uy; r = ux % uy; res = {r[W-1:0], q[W-1:0]}; end
            end
        endcase
        return {z, res};
    endfunction

    // Cycle-level model: idle, or counting down the cycles until completion
    int           m_rem;
    logic         m_busy, m_done, m_dbz, p_dbz;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk or posedge reset) begin
        logic [2*W:0] res;
        if (reset) begin
            m_rem <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0; p_dbz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    res = ref_op(op, a, b);
                    p_dbz  <= res[2*W];
                    p_hi   <= res[2*W-1:W];
                    p_lo   <= res[W-1:0];
                    m_dbz  <= 1'b0;
                    m_busy <= 1'b1;
                    m_rem  <= res[2*W] ? 1 : int'(W) + 2;
                end
            end else if (m_rem == 1) begin
                m_rem  <= 0;
                m_busy <= 1'b0;
                m_done <= 1'b1;
                if (p_dbz) m_dbz <= 1'b1;
                else begin m_hi <= p_hi; m_lo <= p_lo; end
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", 64'(busy), 64'(m_busy));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_dbz",  64'(dbz),  64'(m_dbz));
            check("cyc_hi",   64'(hi),   64'(m_hi));
            check("cyc_lo",   64'(lo),   64'(m_lo));
        end
    end

    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 200);
        check("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int lat;
        int cnt;
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz",  64'(dbz),  64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        check("rst8_hi",  64'(hi8),  64'd0);
        check("rst8_lo",  64'(lo8),  64'd0);
        cmp_en = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // MULT -3 * 7
        launch(2'b00, 32'hFFFF_FFFD, 32'd7);
        check("mult_busy_e0", 64'(busy), 64'd1);
        wait_done(lat);
        check("mult_lat", 64'(lat), 64'd34);
        check("mult_busy_fall", 64'(busy), 64'd0);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        @(posedge clk); #1;
        check("mult_done_1cyc", 64'(done), 64'd0);

        // MULTU max*max, then MULT started in the done cycle
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("b2b_accept", 64'(busy), 64'd1);
        wait_done(lat);
        check("b2b_lat", 64'(lat), 64'd34);
        check("b2b_hi", 64'(hi), 64'd0);
        check("b2b_lo", 64'(lo), 64'd1);

        // Divides
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        launch(2'b11, 32'd7, 32'd2);
        wait_done(lat);
        check("divu_lo", 64'(lo), 64'd3);
        check("divu_hi", 64'(hi), 64'd1);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check("divmin_lo", 64'(lo), 64'h8000_0000);
        check("divmin_hi", 64'(hi), 64'd0);
        check("divmin_dbz", 64'(dbz), 64'd0);

        // Divide by zero after preloading hi=0x11, lo=0x22
        launch(2'b11, 32'h451, 32'h20);
        wait_done(lat);
        check("pre_hi", 64'(hi), 64'h11);
        check("pre_lo", 64'(lo), 64'h22);
        launch(2'b10, 32'd5, 32'd0);
        wait_done(lat);
        check("dbz_lat", 64'(lat), 64'd1);
        check("dbz_flag", 64'(dbz), 64'd1);
        check("dbz_hi", 64'(hi), 64'h11);
        check("dbz_lo", 64'(lo), 64'h22);
        @(posedge clk); #1;
        check("dbz_hold", 64'(dbz), 64'd1);
        launch(2'b11, 32'd7, 32'd2);
        check("dbz_clear", 64'(dbz), 64'd0);
        wait_done(lat);

        // Start ignored while busy
        launch(2'b00, 32'd6, 32'd7);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = k[0]; op = 2'b11; a = 32'(k); b = 32'd1;
        end
        @(negedge clk); start = 1'b0;
        wait_done(lat);
        check("busyprot_hi", 64'(hi), 64'd0);
        check("busyprot_lo", 64'(lo), 64'd42);
        cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (done) cnt++; end
        check("busyprot_single", 64'(cnt), 64'd0);

        // Reset mid-DIVU
        launch(2'b11, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_hi",   64'(hi),   64'd0);
        check("mrst_lo",   64'(lo),   64'd0);
        check("mrst_dbz",  64'(dbz),  64'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        launch(2'b01, 32'd3, 32'd5);
        wait_done(lat);
        check("post_rst_lat", 64'(lat), 64'd34);
        check("post_rst_lo", 64'(lo), 64'd15);
        check("post_rst_hi", 64'(hi), 64'd0);

        // WIDTH=8 instance: MULT -3 * 7
        op8 = 2'b00; a8 = 8'hFD; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h55; b8 = 8'hAA;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!done8 && lat < 50);
        check("w8_done", 64'(done8), 64'd1);
        check("w8_lat", 64'(lat), 64'd10);
        check("w8_busy", 64'(busy8), 64'd0);
        check("w8_hi", 64'(hi8), 64'hFF);
        check("w8_lo", 64'(lo8), 64'hEB);
        check("w8_dbz", 64'(dbz8), 64'd0);

        repeat (3) @(posedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
